// File: rtl/dram_port_arbiter.sv
// Two-port req/ack arbiter that sequences one command at a time into the single-port DRAM controller.
// Build option ARB_ROUND_ROBIN_EN: alternate tie priority between ports; otherwise port A always wins ties.
module dram_port_arbiter #(
   parameter int ADDR_W  = 17,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              a_req,
   input  logic              a_write,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_ena,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_busy,
   output logic              grant,
   output logic              error
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DONE} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             pick_b;

`ifdef ARB_ROUND_ROBIN_EN
   logic prio_b_reg;

   always_comb pick_b = b_req && (!a_req || prio_b_reg);
`else
   always_comb pick_b = b_req && !a_req;
`endif

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         mem_ena   <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         a_rdata   <= '0;
         b_rdata   <= '0;
         grant     <= 1'b0;
         error     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         prio_b_reg <= 1'b0;
`endif
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (!mem_busy && (a_req || b_req)) begin
                  grant     <= pick_b;
                  mem_write <= pick_b ? b_write : a_write;
                  mem_addr  <= pick_b ? b_addr  : a_addr;
                  mem_wdata <= pick_b ? b_wdata : a_wdata;
                  mem_ena   <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                  prio_b_reg <= !pick_b;
`endif
               end
            end
            ISSUE: begin
               if (mem_busy) begin
                  mem_ena   <= 1'b0;
                  state_reg <= WAIT_DONE;
               end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                  // Controller never took the command: abort, flag it, still release the requester.
                  mem_ena   <= 1'b0;
                  error     <= 1'b1;
                  a_ack     <= !grant;
                  b_ack     <= grant;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!mem_busy) begin
                  if (!mem_write) begin
                     if (grant) b_rdata <= mem_rdata;
                     else       a_rdata <= mem_rdata;
                  end
                  a_ack     <= !grant;
                  b_ack     <= grant;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Randomized bench for dram_port_arbiter: transaction-level model of requesters, controller and memory.
// Expected grant order follows ARB_ROUND_ROBIN_EN when that macro is defined.
module tb_dram_port_arbiter;

   localparam int ADDR_W  = 17;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              reset_;
   logic              a_req, a_write, a_ack;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata, a_rdata;
   logic              b_req, b_write, b_ack;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata, b_rdata;
   logic              mem_ena, mem_write, mem_busy, grant, error;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_(reset_),
      .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_ena(mem_ena), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_busy(mem_busy), .grant(grant), .error(error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Golden memory as the requesters see it, and the controller's own storage.
   logic [7:0] gold [0:131071];
   logic [7:0] ram  [0:131071];

   // Transaction-level expectations.
   bit                cmd_active = 0, busy_seen = 0, decide = 1, prio_b = 0, own = 0;
   int                ena_cyc = 0, txn_cnt = 0, a_ack_cnt = 0, b_ack_cnt = 0;
   logic              exp_grant = 0, exp_mem_write = 0, exp_error = 0;
   logic [ADDR_W-1:0] exp_mem_addr = '0;
   logic [DATA_W-1:0] exp_mem_wdata = '0, exp_a_rdata = '0, exp_b_rdata = '0;
   bit                grants [$];

   // Controller model knobs and state.
   int                ctrl_phase = 0, ctrl_cnt = 0, fix_delay = -1, fix_len = -1;
   int                auto_a = 0, auto_b = 0;
   bit                ctrl_dead = 0, refresh_en = 0;
   logic              ctrl_write;
   logic [ADDR_W-1:0] ctrl_addr;
   logic [DATA_W-1:0] ctrl_wdata;

   task automatic new_op(output logic w, output logic [ADDR_W-1:0] ad, output logic [DATA_W-1:0] d);
      int sel;
      sel = int'($urandom_range(3, 0));
      w   = 1'($urandom_range(1, 0));
      d   = 8'($urandom);
      if (sel == 0)      ad = '0;
      else if (sel == 1) ad = 17'h1FFFF;
      else               ad = 17'($urandom_range(31, 0));
   endtask

   task automatic issue_a(input logic w, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
      a_write = w; a_addr = ad; a_wdata = d; a_req = 1'b1;
   endtask

   task automatic issue_b(input logic w, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
      b_write = w; b_addr = ad; b_wdata = d; b_req = 1'b1;
   endtask

   task automatic cycle();
      logic pa, pb, pbusy, dec, ea, eb, exp_ena, done, tmo;
      int   d;
      pa = a_req; pb = b_req; pbusy = mem_busy; dec = decide;
      @(negedge clk);
      ea = 0; eb = 0; exp_ena = 0; done = 0; tmo = 0;
      if (!cmd_active) begin
         if (dec && (pa || pb) && !pbusy) begin
            own = (pa && pb) ? prio_b : pb;
`ifdef ARB_ROUND_ROBIN_EN
            prio_b = !own;
`endif
            cmd_active = 1; busy_seen = 0; ena_cyc = 1; exp_ena = 1;
            exp_grant     = own;
            exp_mem_write = own ? b_write : a_write;
            exp_mem_addr  = own ? b_addr  : a_addr;
            exp_mem_wdata = own ? b_wdata : a_wdata;
            grants.push_back(own);
         end
      end else if (!busy_seen) begin
         if (pbusy) busy_seen = 1;
         else if (ena_cyc == TIMEOUT) begin done = 1; tmo = 1; exp_error = 1; end
         else begin exp_ena = 1; ena_cyc++; end
      end else if (!pbusy) begin
         done = 1;
      end
      if (done) begin
         if (own) eb = 1; else ea = 1;
         if (!tmo) begin
            if (exp_mem_write) gold[exp_mem_addr] = exp_mem_wdata;
            else if (own)      exp_b_rdata = gold[exp_mem_addr];
            else               exp_a_rdata = gold[exp_mem_addr];
         end
         cmd_active = 0;
         txn_cnt++;
         $display("txn %0d: port %s %s addr=%05h data=%02h%s", txn_cnt, own ? "B" : "A",
                  exp_mem_write ? "WR" : "RD", exp_mem_addr,
                  exp_mem_write ? exp_mem_wdata : (own ? exp_b_rdata : exp_a_rdata),
                  tmo ? " (timeout)" : "");
      end
      check("mem_ena",   32'(mem_ena),   32'(exp_ena));
      check("a_ack",     32'(a_ack),     32'(ea));
      check("b_ack",     32'(b_ack),     32'(eb));
      check("grant",     32'(grant),     32'(exp_grant));
      check("mem_write", 32'(mem_write), 32'(exp_mem_write));
      check("mem_addr",  32'(mem_addr),  32'(exp_mem_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(exp_mem_wdata));
      check("error",     32'(error),     32'(exp_error));
      check("a_rdata",   32'(a_rdata),   32'(exp_a_rdata));
      check("b_rdata",   32'(b_rdata),   32'(exp_b_rdata));
      if (a_ack === 1'b1) a_ack_cnt++;
      if (b_ack === 1'b1) b_ack_cnt++;
      decide = !cmd_active && !(ea || eb);
      // Requesters drop req in the ack cycle and may re-request from the next cycle on.
      if (ea) a_req = 1'b0;
      if (eb) b_req = 1'b0;
      if (reset_ && !a_req && !ea && auto_a > 0 && int'($urandom_range(99, 0)) < auto_a) begin
         new_op(a_write, a_addr, a_wdata); a_req = 1'b1;
      end
      if (reset_ && !b_req && !eb && auto_b > 0 && int'($urandom_range(99, 0)) < auto_b) begin
         new_op(b_write, b_addr, b_wdata); b_req = 1'b1;
      end
      case (ctrl_phase)
         0: begin
            if (mem_ena && !ctrl_dead) begin
               ctrl_write = mem_write; ctrl_addr = mem_addr; ctrl_wdata = mem_wdata;
               mem_rdata  = 8'($urandom);
               d = (fix_delay >= 0) ? fix_delay : int'($urandom_range(2, 0));
               if (d == 0) begin
                  mem_busy = 1'b1; ctrl_phase = 2;
                  ctrl_cnt = (fix_len > 0) ? fix_len : int'($urandom_range(5, 1));
               end else begin
                  ctrl_phase = 1; ctrl_cnt = d;
               end
            end else if (refresh_en && !mem_ena && $urandom_range(15, 0) == 0) begin
               mem_busy = 1'b1; ctrl_phase = 3; ctrl_cnt = int'($urandom_range(4, 1));
            end
         end
         1: begin
            ctrl_cnt--;
            if (ctrl_cnt == 0) begin
               mem_busy = 1'b1; ctrl_phase = 2;
               ctrl_cnt = (fix_len > 0) ? fix_len : int'($urandom_range(5, 1));
            end
         end
         2: begin
            ctrl_cnt--;
            mem_rdata = 8'($urandom);
            if (ctrl_cnt == 0) begin
               mem_busy = 1'b0; ctrl_phase = 0;
               if (ctrl_write) ram[ctrl_addr] = ctrl_wdata;
               else            mem_rdata = ram[ctrl_addr];
            end
         end
         default: begin
            ctrl_cnt--;
            if (ctrl_cnt == 0) begin mem_busy = 1'b0; ctrl_phase = 0; end
         end
      endcase
   endtask

   task automatic run_until_quiet(input int budget);
      int k = 0;
      do begin
         cycle();
         k++;
      end while ((a_req || b_req || cmd_active) && k < budget);
      check("quiet", 32'({a_req, b_req, cmd_active}), 32'(0));
   endtask

   task automatic model_reset();
      cmd_active = 0; busy_seen = 0; decide = 1; prio_b = 0;
      exp_grant = 0; exp_mem_write = 0; exp_mem_addr = '0; exp_mem_wdata = '0;
      exp_error = 0; exp_a_rdata = '0; exp_b_rdata = '0;
      a_req = 1'b0; b_req = 1'b0; mem_busy = 1'b0; ctrl_phase = 0; ctrl_dead = 0;
   endtask

   initial begin
      logic exp_seq [4];
      int   k;
      reset_ = 1'b0;
      a_req = 0; a_write = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_write = 0; b_addr = '0; b_wdata = '0;
      mem_rdata = '0; mem_busy = 1'b0;
      for (int i = 0; i < 131072; i++) begin
         ram[i]  = 8'($urandom);
         gold[i] = ram[i];
      end
      #12;
      check("rst_mem_ena", 32'(mem_ena), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_a_rdata", 32'(a_rdata), 0);
      check("rst_error", 32'(error), 0);
      reset_ = 1'b1;

      // Both ports request together, each once: A then B.
      grants.delete();
      issue_a(1'b0, 17'd3, 8'h00);
      issue_b(1'b1, 17'd4, 8'h77);
      run_until_quiet(60);
      check("both_count", 32'(grants.size()), 2);
      if (grants.size() == 2) begin
         check("both_first", 32'(grants[0]), 0);
         check("both_second", 32'(grants[1]), 1);
      end

      // Single A read, busy one cycle after ena for five cycles.
      ram[100] = 8'h5A; gold[100] = 8'h5A;
      fix_delay = 1; fix_len = 5; a_ack_cnt = 0; b_ack_cnt = 0;
      issue_a(1'b0, 17'd100, 8'h00);
      run_until_quiet(60);
      check("t1_a_rdata", 32'(a_rdata), 32'h5A);
      check("t1_mem_addr", 32'(mem_addr), 100);
      check("t1_mem_write", 32'(mem_write), 0);
      check("t1_a_acks", 32'(a_ack_cnt), 1);
      check("t1_b_acks", 32'(b_ack_cnt), 0);

      // Single B write at the top address.
      fix_delay = -1; fix_len = -1; b_ack_cnt = 0;
      issue_b(1'b1, 17'h1FFFF, 8'hC3);
      run_until_quiet(60);
      check("t2_mem_write", 32'(mem_write), 1);
      check("t2_mem_addr", 32'(mem_addr), 32'h1FFFF);
      check("t2_mem_wdata", 32'(mem_wdata), 32'hC3);
      check("t2_b_acks", 32'(b_ack_cnt), 1);
      check("t2_b_rdata", 32'(b_rdata), 0);

      // Controller never answers: timeout, then a normal B read.
      ctrl_dead = 1; a_ack_cnt = 0;
      issue_a(1'b0, 17'd5, 8'h00);
      run_until_quiet(60);
      check("t3_error", 32'(error), 1);
      check("t3_a_acks", 32'(a_ack_cnt), 1);
      ctrl_dead = 0;
      issue_b(1'b0, 17'd7, 8'h00);
      run_until_quiet(60);
      check("t3_b_rdata", 32'(b_rdata), 32'(gold[7]));
      check("t3_error_sticky", 32'(error), 1);

      // Controller busy while idle with a request pending.
      mem_busy = 1'b1; ctrl_phase = 3; ctrl_cnt = 6; grants.delete();
      issue_a(1'b0, 17'd50, 8'h00);
      run_until_quiet(60);
      check("t4_grants", 32'(grants.size()), 1);

      // Reset in the middle of a command.
      fix_len = 20;
      issue_a(1'b0, 17'd9, 8'h00);
      k = 0;
      while (!busy_seen && k < 40) begin cycle(); k++; end
      check("t5_busy_seen", 32'(busy_seen), 1);
      cycle(); cycle();
      #2 reset_ = 1'b0;
      #1;
      check("t5_mem_ena", 32'(mem_ena), 0);
      check("t5_a_ack", 32'(a_ack), 0);
      check("t5_grant", 32'(grant), 0);
      check("t5_mem_addr", 32'(mem_addr), 0);
      check("t5_a_rdata", 32'(a_rdata), 0);
      check("t5_b_rdata", 32'(b_rdata), 0);
      check("t5_error", 32'(error), 0);
      model_reset();
      fix_len = -1;
      repeat (3) cycle();
      reset_ = 1'b1;

      // Both ports held and re-requesting for four commands.
`ifdef ARB_ROUND_ROBIN_EN
      exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      grants.delete();
      issue_a(1'b0, 17'd11, 8'h00);
      issue_b(1'b0, 17'd12, 8'h00);
      auto_a = 100; auto_b = 100;
      k = 0;
      while (grants.size() < 4 && k < 200) begin cycle(); k++; end
      auto_a = 0; auto_b = 0;
      run_until_quiet(100);
      check("rr_count", 32'(grants.size() >= 4), 1);
      for (int i = 0; i < 4; i++)
         if (i < grants.size()) check("rr_seq", 32'(grants[i]), 32'(exp_seq[i]));

      // A read after the reset completes normally.
      a_ack_cnt = 0;
      issue_a(1'b0, 17'd100, 8'h00);
      run_until_quiet(60);
      check("t6_a_rdata", 32'(a_rdata), 32'(gold[100]));
      check("t6_a_acks", 32'(a_ack_cnt), 1);

      // Random traffic from both ports with controller refresh bursts.
      refresh_en = 1; auto_a = 30; auto_b = 30;
      repeat (3000) cycle();
      auto_a = 0; auto_b = 0;
      run_until_quiet(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
